// File: rtl/fpu_f32_div_issue.sv
// Issue/collect controller for a multicycle combinational FP32 divider.
// Launches registered operands, captures the quotient after CYCLES clocks and holds it until accepted.
module fpu_f32_div_issue #(
  parameter int unsigned CYCLES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [31:0]      REQ_A,
  input  logic [31:0]      REQ_B,
  input  logic [TAG_W-1:0] REQ_TAG,
  output logic [31:0]      DIV_A,
  output logic [31:0]      DIV_B,
  input  logic [31:0]      DIV_O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [31:0]      O_DATA,
  output logic [TAG_W-1:0] O_TAG,
  output logic             O_DZ,
  output logic             O_NV,
  output logic             BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_div_a;
  logic [31:0]      r_div_b;
  logic [TAG_W-1:0] r_tag;
  logic             r_dz;
  logic             r_nv;
  logic             r_o_valid;
  logic [31:0]      r_o_data;
  logic [TAG_W-1:0] r_o_tag;
  logic             r_o_dz;
  logic             r_o_nv;

  logic w_a_zero, w_a_inf, w_a_nan;
  logic w_b_zero, w_b_inf, w_b_nan;
  logic w_nv, w_dz;
  logic w_req_ready;
  logic w_accept;

  // Operand classification; denormals count as nonzero finite values.
  always_comb begin
    w_a_zero = (REQ_A[30:0] == '0);
    w_a_inf  = (REQ_A[30:23] == '1) && (REQ_A[22:0] == '0);
    w_a_nan  = (REQ_A[30:23] == '1) && (REQ_A[22:0] != '0);
    w_b_zero = (REQ_B[30:0] == '0);
    w_b_inf  = (REQ_B[30:23] == '1) && (REQ_B[22:0] == '0);
    w_b_nan  = (REQ_B[30:23] == '1) && (REQ_B[22:0] != '0);
    w_nv     = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    w_dz     = w_b_zero && !w_a_zero && !w_a_inf && !w_a_nan && !w_nv;
  end

  assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && O_READY);
  assign w_accept    = REQ_VALID && w_req_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_tag     <= '0;
      r_dz      <= 1'b0;
      r_nv      <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_tag   <= '0;
      r_o_dz    <= 1'b0;
      r_o_nv    <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_o_data  <= DIV_O;
            r_o_tag   <= r_tag;
            r_o_dz    <= r_dz;
            r_o_nv    <= r_nv;
            r_o_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (O_READY) begin
            r_o_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A launch overrides the DONE->IDLE transition so back-to-back requests skip IDLE.
      if (w_accept) begin
        r_div_a <= REQ_A;
        r_div_b <= REQ_B;
        r_tag   <= REQ_TAG;
        r_dz    <= w_dz;
        r_nv    <= w_nv;
        r_cnt   <= CNT_INIT;
        r_state <= S_WAIT;
      end
    end
  end

  assign REQ_READY = w_req_ready;
  assign DIV_A     = r_div_a;
  assign DIV_B     = r_div_b;
  assign O_VALID   = r_o_valid;
  assign O_DATA    = r_o_data;
  assign O_TAG     = r_o_tag;
  assign O_DZ      = r_o_dz;
  assign O_NV      = r_o_nv;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_f32_div_issue.sv
// Scoreboard bench for fpu_f32_div_issue: a CYCLES=4 and a CYCLES=1 instance, each fed by a table-driven divider model.
module tb_fpu_f32_div_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a, b;
  logic [3:0]  tag;

  logic        v0, r0, or0, ov0, dz0, nv0, busy0;
  logic [31:0] da0, db0, do0, od0;
  logic [3:0]  ot0;
  logic        v1, r1, or1, ov1, dz1, nv1, busy1;
  logic [31:0] da1, db1, do1, od1;
  logic [3:0]  ot1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a, b, q;
    logic [3:0]  tag;
    logic        dz, nv;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] fa [8];
  logic [31:0] fb [8];
  logic [31:0] fq [8];
  logic        fdz[8];
  logic        fnv[8];

  fpu_f32_div_issue #(.CYCLES(4), .TAG_W(4)) u_dut0 (
    .CLK(clk), .nRST(rst_n), .REQ_VALID(v0), .REQ_READY(r0), .REQ_A(a), .REQ_B(b),
    .REQ_TAG(tag), .DIV_A(da0), .DIV_B(db0), .DIV_O(do0), .O_VALID(ov0), .O_READY(or0),
    .O_DATA(od0), .O_TAG(ot0), .O_DZ(dz0), .O_NV(nv0), .BUSY(busy0)
  );

  fpu_f32_div_issue #(.CYCLES(1), .TAG_W(4)) u_dut1 (
    .CLK(clk), .nRST(rst_n), .REQ_VALID(v1), .REQ_READY(r1), .REQ_A(a), .REQ_B(b),
    .REQ_TAG(tag), .DIV_A(da1), .DIV_B(db1), .DIV_O(do1), .O_VALID(ov1), .O_READY(or1),
    .O_DATA(od1), .O_TAG(ot1), .O_DZ(dz1), .O_NV(nv1), .BUSY(busy1)
  );

  // Divider stand-in: hand-computed IEEE quotients for the directed operand pairs.
  function automatic logic [31:0] divmodel(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40800000}: return 32'h3E800000;
      {32'h3F800000, 32'h00000000}: return 32'h7F800000;
      {32'h00000000, 32'h80000000}: return 32'h7FC00000;
      {32'h7F800000, 32'h7F800000}: return 32'h7FC00000;
      {32'h7FC00000, 32'h00000000}: return 32'h7FC00000;
      {32'hBF800000, 32'h00000000}: return 32'hFF800000;
      {32'h7F800000, 32'h00000000}: return 32'h7F800000;
      {32'h3F800000, 32'h00000001}: return 32'h7F800000;
      {32'h00000001, 32'h00000000}: return 32'h7F800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  assign do0 = divmodel(da0, db0);
  assign do1 = divmodel(da1, db1);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the CYCLES=4 instance
  logic pv0 = 1'b0;
  logic has0 = 1'b0;
  exp_t cur0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 1'b0;
      has0 = 1'b0;
    end else begin
      if (ov0 && !pv0) begin
        if (q0.size() == 0) chk("unexpected_valid0", 32'd1, 32'd0);
        else begin
          cur0 = q0.pop_front();
          has0 = 1'b1;
          chk("data0", od0, cur0.q);
          chk("tag0", 32'(ot0), 32'(cur0.tag));
          chk("dz0", 32'(dz0), 32'(cur0.dz));
          chk("nv0", 32'(nv0), 32'(cur0.nv));
          chk("latency0", 32'(cyc), 32'(cur0.cyc));
          chk("div_a_held0", da0, cur0.a);
          chk("div_b_held0", db0, cur0.b);
        end
      end else if (ov0 && has0) begin
        chk("hold_data0", od0, cur0.q);
        chk("hold_tag0", 32'(ot0), 32'(cur0.tag));
      end
      pv0 = ov0;
    end
  end

  // Monitor for the CYCLES=1 instance, also tracking result cadence
  logic pv1 = 1'b0;
  exp_t cur1;
  int prev_rise1 = -1;
  int got1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv1 = 1'b0;
    end else begin
      if (ov1 && !pv1) begin
        if (q1.size() == 0) chk("unexpected_valid1", 32'd1, 32'd0);
        else begin
          cur1 = q1.pop_front();
          got1++;
          chk("data1", od1, cur1.q);
          chk("tag1", 32'(ot1), 32'(cur1.tag));
          chk("dz1", 32'(dz1), 32'(cur1.dz));
          chk("nv1", 32'(nv1), 32'(cur1.nv));
          chk("latency1", 32'(cyc), 32'(cur1.cyc));
          if (prev_rise1 >= 0) chk("cadence1", 32'(cyc - prev_rise1), 32'd2);
          prev_rise1 = cyc;
        end
      end
      pv1 = ov1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int d, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [3:0] it, input logic [31:0] iq, input logic idz, input logic inv);
    exp_t e;
    int n = 0;
    a = ia; b = ib; tag = it;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    @(negedge clk);
    while (!(d == 0 ? r0 : r1) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!(d == 0 ? r0 : r1)) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      e.a = ia; e.b = ib; e.q = iq; e.tag = it; e.dz = idz; e.nv = inv;
      e.cyc = cyc + 1 + (d == 0 ? 4 : 1);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Returns at the negedge where the selected instance shows O_VALID.
  task automatic wait_v(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d == 0 ? ov0 : ov1) && n < 60);
    if (!(d == 0 ? ov0 : ov1)) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    fa[0] = 32'h3F800000; fb[0] = 32'h00000000; fq[0] = 32'h7F800000; fdz[0] = 1; fnv[0] = 0;
    fa[1] = 32'h00000000; fb[1] = 32'h80000000; fq[1] = 32'h7FC00000; fdz[1] = 0; fnv[1] = 1;
    fa[2] = 32'h7F800000; fb[2] = 32'h7F800000; fq[2] = 32'h7FC00000; fdz[2] = 0; fnv[2] = 1;
    fa[3] = 32'h7FC00000; fb[3] = 32'h00000000; fq[3] = 32'h7FC00000; fdz[3] = 0; fnv[3] = 1;
    fa[4] = 32'hBF800000; fb[4] = 32'h00000000; fq[4] = 32'hFF800000; fdz[4] = 1; fnv[4] = 0;
    fa[5] = 32'h7F800000; fb[5] = 32'h00000000; fq[5] = 32'h7F800000; fdz[5] = 0; fnv[5] = 0;
    fa[6] = 32'h3F800000; fb[6] = 32'h00000001; fq[6] = 32'h7F800000; fdz[6] = 0; fnv[6] = 0;
    fa[7] = 32'h00000001; fb[7] = 32'h00000000; fq[7] = 32'h7F800000; fdz[7] = 1; fnv[7] = 0;

    rst_n = 1'b1; v0 = 0; v1 = 0; or0 = 0; or1 = 0; a = '0; b = '0; tag = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_div_a", da0, 32'd0);
    chk("rst_div_b", db0, 32'd0);
    chk("rst_data", od0, 32'd0);
    chk("rst_tag", 32'(ot0), 32'd0);
    chk("rst_flags", 32'({dz0, nv0}), 32'd0);
    chk("rst_req_ready", 32'(r0), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic latency, then backpressure with an ignored request pending
    send(0, 32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 1'b0, 1'b0);
    chk("busy_accept", 32'(busy0), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("busy_wait", 32'(busy0), 32'd1);
      chk("no_early_valid", 32'(ov0), 32'd0);
    end
    wait_v(0);
    a = 32'h12345678; b = 32'h9ABCDEF0; tag = 4'hF; v0 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov0), 32'd1);
      chk("bp_req_ready", 32'(r0), 32'd0);
      chk("bp_busy", 32'(busy0), 32'd1);
    end
    @(posedge clk);
    #1 or0 = 1'b1;
    #1 chk("req_ready_follows_o_ready", 32'(r0), 32'd1);

    // Back-to-back: second request accepted on the first handshake edge
    send(0, 32'h3F800000, 32'h40800000, 4'd5, 32'h3E800000, 1'b0, 1'b0);
    chk("b2b_valid_drop", 32'(ov0), 32'd0);
    chk("b2b_busy", 32'(busy0), 32'd1);
    wait_v(0);
    @(posedge clk);
    #1;
    chk("idle_after_hs_valid", 32'(ov0), 32'd0);
    chk("idle_after_hs_busy", 32'(busy0), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(0, fa[i], fb[i], 4'(i + 6), fq[i], fdz[i], fnv[i]);
      wait_v(0);
      @(posedge clk);
      #1;
    end

    // Reset two cycles after accept discards the request
    send(0, 32'h40C00000, 32'h40000000, 4'd9, 32'h40400000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    q0.delete();
    chk("midrst_valid", 32'(ov0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_div_a", da0, 32'd0);
    chk("midrst_div_b", db0, 32'd0);
    chk("midrst_data", od0, 32'd0);
    chk("midrst_tag", 32'(ot0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(ov0), 32'd0);
    end
    @(posedge clk);
    #1;
    send(0, 32'h3F800000, 32'h40800000, 4'hA, 32'h3E800000, 1'b0, 1'b0);
    wait_v(0);
    @(posedge clk);
    #1;

    // CYCLES=1 instance: sustained back-to-back, one result every two clocks
    or1 = 1'b1;
    for (int i = 0; i < 5; i++) send(1, fa[i], fb[i], 4'(i + 1), fq[i], fdz[i], fnv[i]);
    for (int n = 0; n < 40 && got1 < 5; n++) @(negedge clk);
    chk("burst1_results", 32'(got1), 32'd5);
    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
